uart_tx_arbiter: RTL and testbench

//   Shares the single UART transmitter (byte interface: tx_data/tx_start/tx_busy) among
//   N byte-stream requesters (key events, MCU echo, status reporter, ...).
//   - Round-robin arbitration at packet granularity: a grant is held until the requester's last byte.
//   - Sits between the producers and the uart_try TX path in Top.

---
 rtl/uart_tx_arbiter_pkg.sv | 28 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter.
//   - arb_state_e : FSM state encoding (IDLE=0, HDR=1, SEND=2, WAIT_HI=3, WAIT_LO=4)
//   - HDR_BASE_DEFAULT : default header byte base (header mode only)
//   - MAX_N_REQ : largest supported requester count
//   - WAIT_HI_LIMIT : cycles WAIT_HI waits for tx_busy before assuming the frame was consumed
//   - id_width() : clog2 with a floor of 1, used for grant_id width
package uart_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_SEND    = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4
  } arb_state_e;

  localparam logic [7:0] HDR_BASE_DEFAULT = 8'hA0;
  localparam int         MAX_N_REQ        = 8;
  localparam logic [1:0] WAIT_HI_LIMIT    = 2'd2;

  function automatic int id_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational N-way round-robin picker.
//   req    : request vector
//   ptr    : index with highest priority this cycle (must be < N)
//   gnt_id : first set request at or after ptr, wrapping past N-1
//   any    : at least one request is set
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] gnt_id,
  output logic           any
);

  // One extra bit so ptr + k never overflows before the wrap subtraction.
  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  always_comb begin
    gnt_id = '0;
    any    = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      sum = (IDW+1)'(ptr) + (IDW+1)'(k);
      if (sum >= (IDW+1)'(N)) sum = sum - (IDW+1)'(N);
      idx = sum[IDW-1:0];
      if (!any && req[idx]) begin
        any    = 1'b1;
        gnt_id = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one byte-wide UART transmitter among N_REQ byte-stream requesters.
// Round-robin at packet granularity: once granted, a requester keeps the
// transmitter until its byte flagged req_last has been sent.
//
// Optional feature: define UART_ARB_HDR_EN to prefix every packet with one
// header byte HDR_BASE + grant_id. Without it the stream is payload only.
//
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   req_valid/req_last/req_data/req_ready : per-requester byte streams
//   tx_data, tx_start, tx_busy : transmitter byte interface
//   grant_id, grant_active : current owner and packet-in-progress flag
//
// Handshake: requester i transfers a byte on a cycle where req_valid[i] and
// req_ready[i] are both high. req_ready is combinational from state and
// tx_busy and never depends on req_valid; a requester may raise or drop
// req_valid at any time, and req_data/req_last are sampled only on transfer.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int         N_REQ    = 4,
  parameter int         IDW      = id_width(N_REQ),
  parameter logic [7:0] HDR_BASE = HDR_BASE_DEFAULT
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_last,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_busy,
  output logic [IDW-1:0]     grant_id,
  output logic               grant_active
);

  arb_state_e     state, state_n;
  logic [IDW-1:0] rr_ptr, rr_ptr_n;
  logic [IDW-1:0] grant_id_q, grant_id_n;
  logic           grant_active_q, grant_active_n;
  logic [7:0]     tx_data_q, tx_data_n;
  logic           tx_start_q, tx_start_n;
  logic           last_q, last_n;
  logic [1:0]     guard_q, guard_n;

  logic [IDW-1:0] pick_id;
  logic           pick_any;

  rr_pick #(.N(N_REQ), .IDW(IDW)) u_rr_pick (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  assign tx_data      = tx_data_q;
  assign tx_start     = tx_start_q;
  assign grant_id     = grant_id_q;
  assign grant_active = grant_active_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= ST_IDLE;
      rr_ptr         <= '0;
      grant_id_q     <= '0;
      grant_active_q <= 1'b0;
      tx_data_q      <= 8'h00;
      tx_start_q     <= 1'b0;
      last_q         <= 1'b0;
      guard_q        <= '0;
    end else begin
      state          <= state_n;
      rr_ptr         <= rr_ptr_n;
      grant_id_q     <= grant_id_n;
      grant_active_q <= grant_active_n;
      tx_data_q      <= tx_data_n;
      tx_start_q     <= tx_start_n;
      last_q         <= last_n;
      guard_q        <= guard_n;
    end
  end

  always_comb begin
    state_n        = state;
    rr_ptr_n       = rr_ptr;
    grant_id_n     = grant_id_q;
    grant_active_n = grant_active_q;
    tx_data_n      = tx_data_q;
    tx_start_n     = 1'b0;
    last_n         = last_q;
    guard_n        = guard_q;
    req_ready      = '0;

    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          grant_id_n     = pick_id;
          grant_active_n = 1'b1;
`ifdef UART_ARB_HDR_EN
          state_n        = ST_HDR;
`else
          state_n        = ST_SEND;
`endif
        end
      end

      // Only reachable when the header feature is compiled in.
      ST_HDR: begin
        tx_data_n  = HDR_BASE + 8'(grant_id_q);
        tx_start_n = 1'b1;
        last_n     = 1'b0;
        guard_n    = '0;
        state_n    = ST_WAIT_HI;
      end

      ST_SEND: begin
        if (!tx_busy) begin
          req_ready[grant_id_q] = 1'b1;
          if (req_valid[grant_id_q]) begin
            tx_data_n  = req_data[{grant_id_q, 3'b000} +: 8];
            last_n     = req_last[grant_id_q];
            tx_start_n = 1'b1;
            guard_n    = '0;
            state_n    = ST_WAIT_HI;
          end
        end
      end

      // A transmitter that finishes very fast may never show tx_busy;
      // the guard stops us waiting forever for a rising edge.
      ST_WAIT_HI: begin
        if (tx_busy || guard_q == WAIT_HI_LIMIT) state_n = ST_WAIT_LO;
        else                                     guard_n = guard_q + 2'd1;
      end

      ST_WAIT_LO: begin
        if (!tx_busy) begin
          if (last_q) begin
            state_n        = ST_IDLE;
            grant_active_n = 1'b0;
            grant_id_n     = '0;
            rr_ptr_n       = (grant_id_q == IDW'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
          end else begin
            state_n = ST_SEND;
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a transmitter model and a
// scoreboard of expected {grant_id, tx_data} pairs. Compile with
// UART_ARB_HDR_EN defined to expect the per-packet header byte.
module tb_uart_tx_arbiter;

  localparam int         N        = 4;
  localparam int         IDW      = 2;
  localparam int         W        = IDW + 8;
  localparam logic [7:0] HDR_BASE = 8'hA0;

  logic             sys_clk;
  logic             sys_rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_last;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic             tx_busy;
  logic [IDW-1:0]   grant_id;
  logic             grant_active;

  logic [W-1:0]     exp_q[$];
  logic [8:0]       ch_q[N][$];
  logic [N-1:0]     stall;
  logic [N-1:0]     acc;
  logic [W-1:0]     mon_exp;
  int               busy_cnt = 0;
  int               cmp_cnt  = 0;
  int               err_cnt  = 0;

  uart_tx_arbiter #(.N_REQ(N), .IDW(IDW), .HDR_BASE(HDR_BASE)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .grant_id     (grant_id),
    .grant_active (grant_active)
  );

  // Clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  // Transmitter model: busy from the cycle after tx_start, for 10 cycles.
  always @(posedge sys_clk) begin
    if (tx_start)          busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every tx_start must match the next expected byte.
  always @(negedge sys_clk) begin
    if (sys_rst_n && tx_start) begin
      check("tx_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        check("tx_grant_and_byte", 32'({grant_id, tx_data}), 32'(mon_exp));
      end
    end
  end

  // Driver tasks
  task automatic drive();
    logic [8:0] e;
    for (int i = 0; i < N; i++) begin
      if (ch_q[i].size() != 0 && !stall[i]) begin
        e = ch_q[i][0];
        req_valid[i]      = 1'b1;
        req_last[i]       = e[8];
        req_data[8*i +: 8] = e[7:0];
      end else begin
        req_valid[i]      = 1'b0;
        req_last[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
      end
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    acc = req_valid & req_ready;
    @(posedge sys_clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i] && ch_q[i].size() > 0) void'(ch_q[i].pop_front());
    if (acc != '0) check("start_latency", 32'(tx_start), 32'd1);
    drive();
  endtask

  task automatic push_pkt(input int ch, input int n,
                          input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] b;
`ifdef UART_ARB_HDR_EN
    exp_q.push_back({IDW'(ch), 8'(HDR_BASE + 8'(ch))});
`endif
    for (int k = 0; k < n; k++) begin
      b = (k == 0) ? b0 : (k == 1) ? b1 : b2;
      ch_q[ch].push_back({(k == n - 1), b});
      exp_q.push_back({IDW'(ch), b});
    end
    drive();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit done;
    bit empty;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      tick();
      empty = (exp_q.size() == 0);
      for (int i = 0; i < N; i++) if (ch_q[i].size() != 0) empty = 1'b0;
      done = empty && !grant_active && !tx_busy;
    end
    check({tag, "_complete"}, 32'(done), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req_ready"},    32'(req_ready),    32'd0);
    check({tag, "_tx_data"},      32'(tx_data),      32'd0);
    check({tag, "_tx_start"},     32'(tx_start),     32'd0);
    check({tag, "_grant_id"},     32'(grant_id),     32'd0);
    check({tag, "_grant_active"}, 32'(grant_active), 32'd0);
    check({tag, "_rr_ptr"},       32'(dut.rr_ptr),   32'd0);
  endtask

  initial begin
    int n;
    sys_rst_n = 1'b0;
    stall     = '0;
    acc       = '0;
    drive();
    repeat (3) @(posedge sys_clk);
    #1;
    check_reset("reset");
    sys_rst_n = 1'b1;

    // 1. Single requester, three bytes.
    push_pkt(0, 3, 8'h11, 8'h22, 8'h33);
    wait_idle("t1", 300);
    check("t1_grant_active", 32'(grant_active), 32'd0);
    check("t1_rr_ptr", 32'(dut.rr_ptr), 32'd1);

    // 2. Contention from reset: order 0,1,2,3,0.
    sys_rst_n = 1'b0;
    push_pkt(0, 2, 8'h01, 8'h02, 8'h00);
    push_pkt(1, 2, 8'h13, 8'h14, 8'h00);
    push_pkt(2, 2, 8'h25, 8'h26, 8'h00);
    push_pkt(3, 2, 8'h37, 8'h38, 8'h00);
    push_pkt(0, 2, 8'h09, 8'h0A, 8'h00);
    tick();
    tick();
    check_reset("t2_reset");
    sys_rst_n = 1'b1;
    wait_idle("t2", 1000);
    check("t2_rr_ptr", 32'(dut.rr_ptr), 32'd1);

    // 3. Wrap: ch2 alone leaves rr_ptr=3, then ch0 and ch2 together.
    push_pkt(2, 1, 8'h5A, 8'h00, 8'h00);
    wait_idle("t3a", 300);
    check("t3_rr_ptr_after_ch2", 32'(dut.rr_ptr), 32'd3);
    push_pkt(0, 2, 8'h61, 8'h62, 8'h00);
    push_pkt(2, 2, 8'h71, 8'h72, 8'h00);
    wait_idle("t3b", 500);
    check("t3_rr_ptr_end", 32'(dut.rr_ptr), 32'd3);

    // 4. Owner ch1 stalls mid-packet while ch2 requests.
    push_pkt(1, 3, 8'h81, 8'h82, 8'h83);
    n = 0;
    while (ch_q[1].size() != 2 && n < 100) begin tick(); n++; end
    check("t4_first_byte_taken", 32'(ch_q[1].size()), 32'd2);
    stall[1] = 1'b1;
    drive();
    push_pkt(2, 2, 8'h91, 8'h92, 8'h00);
    for (int c = 0; c < 50; c++) begin
      tick();
      check("t4_ch2_ready", 32'(req_ready[2]), 32'd0);
      check("t4_grant_id",  32'(grant_id),     32'd1);
    end
    stall[1] = 1'b0;
    drive();
    wait_idle("t4", 500);
    check("t4_rr_ptr", 32'(dut.rr_ptr), 32'd3);

    // 5. Reset during WAIT_LO, then a clean packet.
    push_pkt(0, 2, 8'hC1, 8'hC2, 8'h00);
    n = 0;
    while (!tx_busy && n < 50) begin tick(); n++; end
    check("t5_busy_seen", 32'(tx_busy), 32'd1);
    tick();
    tick();
    tick();
    sys_rst_n = 1'b0;
    #1;
    check_reset("t5_reset");
    exp_q.delete();
    ch_q[0].delete();
    drive();
    n = 0;
    while (tx_busy && n < 30) begin tick(); n++; end
    sys_rst_n = 1'b1;
    push_pkt(0, 3, 8'hD1, 8'hD2, 8'hD3);
    wait_idle("t5", 300);
    check("t5_rr_ptr", 32'(dut.rr_ptr), 32'd1);

    // 6. ch2 single byte 55 (header A2 first when the feature is built in).
    push_pkt(2, 1, 8'h55, 8'h00, 8'h00);
    wait_idle("t6", 300);
    check("t6_rr_ptr", 32'(dut.rr_ptr), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
